// File: rtl/bp_nonsynth_axi_nbf_receiver_pkg.sv
// Shared types and constants for the AXI-Lite NBF receiver.
package bp_nonsynth_axi_nbf_receiver_pkg;

  localparam int unsigned nbf_opcode_width_lp = 8;
  localparam int unsigned nbf_addr_width_lp   = 64;
  localparam int unsigned nbf_data_width_lp   = 64;
  localparam int unsigned nbf_flits_lp        = 5;
  localparam int unsigned nbf_idx_width_lp    = $clog2(nbf_flits_lp);
  localparam int unsigned nbf_count_width_lp  = 16;

  localparam logic [nbf_opcode_width_lp-1:0] e_nbf_finish = 8'hFF;

  localparam logic [1:0] axi_resp_okay_lp   = 2'b00;
  localparam logic [1:0] axi_resp_slverr_lp = 2'b10;

  typedef struct packed {
    logic [nbf_opcode_width_lp-1:0] opcode;
    logic [nbf_addr_width_lp-1:0]   addr;
    logic [nbf_data_width_lp-1:0]   data;
  } bp_nbf_s;

  typedef enum logic {
    e_idle,
    e_resp
  } wr_state_e;

endpackage

// File: rtl/bp_nonsynth_axi_nbf_receiver_counter.sv
// Up counter with synchronous clear; clear has priority and may be combined with up.
module bsg_counter_clear_up #(
  parameter int unsigned max_val_p = 4,
  parameter int unsigned width_p   = $clog2(max_val_p + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_up,
  output logic [width_p-1:0] o_count
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= width_p'(i_up);
    end else if (i_up) begin
      r_count <= r_count + width_p'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/bp_nonsynth_axi_nbf_receiver.sv
// AXI-Lite subordinate that reassembles 32-bit NBF flits into 136-bit commands
// and presents them on a valid/ready port; a finish opcode sets a sticky done.
module bp_nonsynth_axi_nbf_receiver
  import bp_nonsynth_axi_nbf_receiver_pkg::*;
#(
  parameter int unsigned S_AXIL_ADDR_WIDTH = 64,
  parameter int unsigned S_AXIL_DATA_WIDTH = 32,
  parameter logic [63:0] nbf_host_addr_p   = 64'h0
) (
  input  logic                           s_axil_aclk,
  input  logic                           s_axil_aresetn,
  input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [2:0]                     s_axil_awprot,
  input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  output logic [1:0]                     s_axil_bresp,
  input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  input  logic [2:0]                     s_axil_arprot,
  output logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [1:0]                     s_axil_rresp,
  output bp_nbf_s                        nbf_o,
  output logic                           nbf_v_o,
  input  logic                           nbf_ready_i,
  output logic                           done_o
);

  localparam int unsigned idx_w_lp = nbf_idx_width_lp;
  localparam int unsigned cnt_w_lp = nbf_count_width_lp;

  wr_state_e                      r_state, w_state_n;
  logic                           r_ready_en;
  logic                           r_aw_held, r_w_held;
  logic [S_AXIL_ADDR_WIDTH-1:0]   r_awaddr;
  logic [S_AXIL_DATA_WIDTH-1:0]   r_wdata;
  logic [1:0]                     r_bresp;
  logic [nbf_data_width_lp-1:0]   r_data;
  logic [nbf_addr_width_lp-1:0]   r_addr;
  bp_nbf_s                        r_nbf;
  logic                           r_nbf_v;
  logic                           r_done;
  logic [cnt_w_lp-1:0]            r_delivered;
  logic                           r_rvalid;
  logic [S_AXIL_DATA_WIDTH-1:0]   r_rdata;

  logic [idx_w_lp-1:0] w_idx;
  logic w_commit, w_accept, w_last;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_nbf_hs;
  logic w_unused;

  // Ready gating is held off for one cycle after reset release.
  assign s_axil_awready = r_ready_en & (r_state == e_idle) & ~r_aw_held & ~r_nbf_v;
  assign s_axil_wready  = r_ready_en & (r_state == e_idle) & ~r_w_held  & ~r_nbf_v;
  assign s_axil_arready = r_ready_en & ~r_rvalid;
  assign s_axil_bvalid  = (r_state == e_resp);
  assign s_axil_bresp   = r_bresp;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = axi_resp_okay_lp;
  assign nbf_o          = r_nbf;
  assign nbf_v_o        = r_nbf_v;
  assign done_o         = r_done;

  assign w_aw_hs  = s_axil_awvalid & s_axil_awready;
  assign w_w_hs   = s_axil_wvalid & s_axil_wready;
  assign w_ar_hs  = s_axil_arvalid & s_axil_arready;
  assign w_nbf_hs = r_nbf_v & nbf_ready_i;
  assign w_accept = (r_awaddr == S_AXIL_ADDR_WIDTH'(nbf_host_addr_p)) & ~r_done;
  assign w_last   = (w_idx == idx_w_lp'(nbf_flits_lp - 1));

  assign w_unused = ^{s_axil_awprot, s_axil_wstrb, s_axil_araddr, s_axil_arprot};

  bsg_counter_clear_up #(
    .max_val_p(nbf_flits_lp - 1),
    .width_p  (idx_w_lp)
  ) u_word_idx (
    .i_clk  (s_axil_aclk),
    .i_rst_n(s_axil_aresetn),
    .i_clear(w_commit & w_accept & w_last),
    .i_up   (w_commit & w_accept & ~w_last),
    .o_count(w_idx)
  );

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      r_state <= e_idle;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Commit fires on the transition into the response state.
  always_comb begin
    w_state_n = r_state;
    w_commit  = 1'b0;
    case (r_state)
      e_idle: begin
        if (r_aw_held && r_w_held) begin
          w_state_n = e_resp;
          w_commit  = 1'b1;
        end
      end
      e_resp: begin
        if (s_axil_bready) begin
          w_state_n = e_idle;
        end
      end
    endcase
  end

  // AW and W are captured independently and released together at commit.
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      r_ready_en <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= s_axil_awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= s_axil_wdata;
        end
      end
    end
  end

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      r_bresp     <= axi_resp_okay_lp;
      r_data      <= '0;
      r_addr      <= '0;
      r_nbf       <= '0;
      r_nbf_v     <= 1'b0;
      r_done      <= 1'b0;
      r_delivered <= '0;
    end else begin
      if (w_commit) begin
        r_bresp <= w_accept ? axi_resp_okay_lp : axi_resp_slverr_lp;
      end
      if (w_commit && w_accept) begin
        case (w_idx)
          idx_w_lp'(0): r_data[31:0]  <= r_wdata[31:0];
          idx_w_lp'(1): r_data[63:32] <= r_wdata[31:0];
          idx_w_lp'(2): r_addr[31:0]  <= r_wdata[31:0];
          idx_w_lp'(3): r_addr[63:32] <= r_wdata[31:0];
          default: begin
            r_nbf.opcode <= r_wdata[7:0];
            r_nbf.addr   <= r_addr;
            r_nbf.data   <= r_data;
          end
        endcase
      end
      if (w_commit && w_accept && w_last) begin
        r_nbf_v <= 1'b1;
      end else if (w_nbf_hs) begin
        r_nbf_v <= 1'b0;
      end
      // Delivered count saturates rather than wrapping.
      if (w_nbf_hs) begin
        if (r_delivered != '1) begin
          r_delivered <= r_delivered + cnt_w_lp'(1);
        end
        if (r_nbf.opcode == e_nbf_finish) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (r_rvalid) begin
      if (s_axil_rready) begin
        r_rvalid <= 1'b0;
      end
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= S_AXIL_DATA_WIDTH'(r_delivered);
    end
  end

endmodule

// File: tb/tb_bp_nonsynth_axi_nbf_receiver.sv
// Scoreboard bench for the AXI-Lite NBF receiver with a word-list reference model.
module tb_bp_nonsynth_axi_nbf_receiver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0]  awaddr = '0;
  logic         awvalid = 1'b0;
  logic [2:0]   awprot = '0;
  logic [31:0]  wdata = '0;
  logic         wvalid = 1'b0;
  logic [3:0]   wstrb = 4'hF;
  logic         bready = 1'b0;
  logic [63:0]  araddr = '0;
  logic         arvalid = 1'b0;
  logic [2:0]   arprot = '0;
  logic         rready = 1'b0;
  logic         nbf_ready = 1'b0;
  logic         awready, wready, bvalid, arready, rvalid, nbf_v, done;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [135:0] nbf;

  bp_nonsynth_axi_nbf_receiver dut (
    .s_axil_aclk   (clk),
    .s_axil_aresetn(rst_n),
    .s_axil_awaddr (awaddr),
    .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_awprot (awprot),
    .s_axil_wdata  (wdata),
    .s_axil_wvalid (wvalid),
    .s_axil_wready (wready),
    .s_axil_wstrb  (wstrb),
    .s_axil_bvalid (bvalid),
    .s_axil_bready (bready),
    .s_axil_bresp  (bresp),
    .s_axil_araddr (araddr),
    .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_arprot (arprot),
    .s_axil_rdata  (rdata),
    .s_axil_rvalid (rvalid),
    .s_axil_rready (rready),
    .s_axil_rresp  (rresp),
    .nbf_o         (nbf),
    .nbf_v_o       (nbf_v),
    .nbf_ready_i   (nbf_ready),
    .done_o        (done)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [135:0] exp_nbf[$];
  logic [1:0]   exp_b[$];
  logic [31:0]  exp_r[$];

  // Reference model: accepted words collected per command, commands counted since reset.
  logic [31:0] m_words[$];
  int          m_cmds = 0;
  bit          m_done = 1'b0;

  int           b_seen = 0;
  int           r_seen = 0;
  bit           aw_acc, w_acc;
  bit           hold_nbf = 1'b0;
  bit           prev_wait = 1'b0;
  logic [135:0] prev_nbf;

  function automatic void check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  function automatic void model_write(input logic [63:0] a, input logic [31:0] d);
    logic [31:0] w4;
    if (a == 64'h0 && !m_done) begin
      exp_b.push_back(2'b00);
      m_words.push_back(d);
      if (m_words.size() == 5) begin
        w4 = m_words[4];
        exp_nbf.push_back({w4[7:0], m_words[3], m_words[2], m_words[1], m_words[0]});
        m_cmds++;
        if (w4[7:0] == 8'hFF) m_done = 1'b1;
        m_words.delete();
      end
    end else begin
      exp_b.push_back(2'b10);
    end
  endfunction

  function automatic void model_reset();
    m_words.delete();
    exp_nbf.delete();
    exp_b.delete();
    exp_r.delete();
    m_cmds = 0;
    m_done = 1'b0;
  endfunction

  // Random sink-side readiness.
  always @(posedge clk) begin
    #1;
    bready    = ($urandom_range(0, 3) != 0);
    rready    = ($urandom_range(0, 3) != 0);
    nbf_ready = hold_nbf ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops expectations whenever the DUT completes a handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (nbf_v) check("bp_gate", {134'b0, awready, wready}, '0);
      if (prev_wait) check("nbf_stable", nbf, prev_nbf);
      if (nbf_v && nbf_ready) begin
        if (exp_nbf.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL nbf_unexpected: got %h expected none", nbf);
        end else begin
          check("nbf_cmd", nbf, exp_nbf.pop_front());
        end
      end
      prev_wait = nbf_v && !nbf_ready;
      prev_nbf  = nbf;
      if (bvalid && bready) begin
        check("b_after_aw_w", {134'b0, aw_acc, w_acc}, 136'b11);
        if (exp_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected: got %b expected none", bresp);
        end else begin
          check("bresp", 136'(bresp), 136'(exp_b.pop_front()));
        end
        b_seen++;
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL r_unexpected: got %h expected none", rdata);
        end else begin
          check("rdata", {102'b0, rresp, rdata}, {104'b0, exp_r.pop_front()});
        end
        r_seen++;
      end
    end else begin
      prev_wait = 1'b0;
    end
  end

  task automatic drive_aw(input logic [63:0] a, input int dly);
    repeat (dly) @(posedge clk);
    #1;
    awaddr  = a;
    awprot  = 3'($urandom);
    awvalid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (awready) begin
        aw_acc = 1'b1;
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        return;
      end
    end
    awvalid = 1'b0;
    timeout("aw_handshake");
  endtask

  task automatic drive_w(input logic [31:0] d, input int dly);
    repeat (dly) @(posedge clk);
    #1;
    wdata  = d;
    wvalid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (wready) begin
        w_acc = 1'b1;
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        return;
      end
    end
    wvalid = 1'b0;
    timeout("w_handshake");
  endtask

  task automatic write_word(input logic [63:0] a, input logic [31:0] d, input int da, input int dw);
    int start;
    bit ok;
    model_write(a, d);
    aw_acc = 1'b0;
    w_acc  = 1'b0;
    start  = b_seen;
    fork
      drive_aw(a, da);
      drive_w(d, dw);
    join
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      if (b_seen != start) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) timeout("b_handshake");
  endtask

  task automatic send_cmd(input logic [159:0] words, input bit rnd);
    for (int i = 0; i < 5; i++) begin
      write_word(64'h0, words[i*32 +: 32],
                 rnd ? int'($urandom_range(0, 3)) : 0,
                 rnd ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic read_count();
    int start;
    bit ok;
    start = r_seen;
    exp_r.push_back(32'(m_cmds));
    araddr  = {$urandom, $urandom};
    arprot  = 3'($urandom);
    arvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (arready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    if (!ok) timeout("ar_handshake");
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (r_seen != start) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) timeout("r_handshake");
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (exp_nbf.size() == 0 && !nbf_v) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("nbf_drain");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    @(negedge clk);
    check("rst_handshake", {130'b0, awready, wready, arready, bvalid, rvalid, nbf_v}, '0);
    check("rst_nbf", nbf, '0);
    check("rst_misc", {101'b0, done, bresp, rdata}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("idle_ready", {133'b0, awready, wready, arready}, 136'b111);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [159:0] words;
    logic [159:0] w_ex;
    logic [31:0]  op;
    logic [63:0]  bad;

    @(posedge clk);
    #1;
    do_reset();

    // Basic command, AW and W together.
    w_ex = {32'h0000_0002, 32'h0000_0080, 32'h0000_1000, 32'h0123_4567, 32'h89AB_CDEF};
    send_cmd(w_ex, 1'b0);
    drain();

    // Skewed AW/W arrival on words 2 and 3.
    write_word(64'h0, 32'h89AB_CDEF, 0, 0);
    write_word(64'h0, 32'h0123_4567, 0, 0);
    write_word(64'h0, 32'h0000_1000, 3, 0);
    write_word(64'h0, 32'h0000_0080, 0, 2);
    write_word(64'h0, 32'h0000_0002, 0, 0);
    drain();

    // Misaddressed word mid-command is discarded.
    write_word(64'h0, 32'h1111_1111, 0, 0);
    write_word(64'h0, 32'h2222_2222, 1, 0);
    write_word(64'h40, 32'hDEAD_BEEF, 0, 0);
    write_word(64'h0, 32'h3333_3333, 0, 1);
    write_word(64'h0, 32'h4444_4444, 0, 0);
    write_word(64'h0, 32'hABCD_EF10, 0, 0);
    drain();

    // Consumer stalls; host pushes the next command behind it.
    hold_nbf = 1'b1;
    send_cmd({32'h0000_0003, 32'hCAFE_0000, 32'h0000_2000, 32'h5555_6666, 32'h7777_8888}, 1'b0);
    fork
      send_cmd({32'h0000_0004, 32'h0000_0001, 32'h0000_3000, 32'h9999_AAAA, 32'hBBBB_CCCC}, 1'b1);
      begin
        for (int k = 0; k < 200 && !nbf_v; k++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        hold_nbf = 1'b0;
      end
    join
    drain();

    // Randomized commands with occasional misaddressed writes and junk upper opcode bits.
    for (int c = 0; c < 20; c++) begin
      words = {$urandom, $urandom, $urandom, $urandom, $urandom};
      op = words[159:128];
      if (op[7:0] == 8'hFF) op[7:0] = 8'h01;
      words[159:128] = op;
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          bad = 64'($urandom_range(1, 4096)) << 2;
          write_word(bad, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        write_word(64'h0, words[i*32 +: 32], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end
    drain();
    read_count();

    // Finish command, then writes are refused.
    check("done_before_finish", 136'(done), '0);
    send_cmd({32'h0000_00FF, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b0);
    drain();
    check("done_after_finish", 136'(done), 136'(1));
    write_word(64'h0, 32'h1234_5678, 0, 0);
    read_count();
    check("done_sticky", 136'(done), 136'(1));

    // Reset part way through a command.
    write_word(64'h0, 32'hAAAA_0001, 0, 0);
    write_word(64'h0, 32'hAAAA_0002, 0, 0);
    write_word(64'h0, 32'hAAAA_0003, 0, 0);
    do_reset();
    send_cmd({32'h0000_0005, 32'h0000_0000, 32'h0000_4000, 32'hFEED_F00D, 32'h0BAD_CAFE}, 1'b1);
    drain();
    read_count();
    check("done_cleared", 136'(done), '0);

    repeat (5) @(posedge clk);
    check("queues_empty", 136'(exp_nbf.size() + exp_b.size() + exp_r.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_axi_nbf_receiver.md
Name: bp_nonsynth_axi_nbf_receiver

Overview:
- AXI-Lite subordinate that accepts the serialized NBF write stream and reassembles 32-bit words into 136-bit NBF commands (opcode/addr/data).
- Emits each command on a valid/ready port; a finish command (opcode 8'hFF) sets sticky done_o.
- Used in testbenches as the far end of the host-to-device NBF load path, in front of the NBF-to-BedRock converter.

Parameters:
- S_AXIL_ADDR_WIDTH, 64, AXI-Lite address width.
- S_AXIL_DATA_WIDTH, 32, AXI-Lite data width; must be 32.
- nbf_host_addr_p, 64'h0, the only write address accepted as NBF data.

Ports:
s_axil_aclk  in  1  clock
s_axil_aresetn  in  1  reset; asynchronous, active-low
s_axil_awaddr  in  S_AXIL_ADDR_WIDTH  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_awprot  in  3  ignored
s_axil_wdata  in  S_AXIL_DATA_WIDTH  write data
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_wstrb  in  S_AXIL_DATA_WIDTH/8  ignored; full-word writes only
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_bresp  out  2  2'b00 OKAY / 2'b10 SLVERR
s_axil_araddr  in  S_AXIL_ADDR_WIDTH  ignored
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_arprot  in  3  ignored
s_axil_rdata  out  S_AXIL_DATA_WIDTH  read data = commands delivered count
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
s_axil_rresp  out  2  always 2'b00
nbf_o  out  136  assembled command {opcode[7:0], addr[63:0], data[63:0]}
nbf_v_o  out  1  command valid
nbf_ready_i  in  1  command ready
done_o  out  1  sticky; finish command delivered

Behaviour:
- Reset (async assert, sync release): all valid/ready outputs 0, bresp/rresp/rdata 0, word counter 0, delivered count 0, done_o 0, nbf_o 0.
- Flit order: 5 words per command, index 0..4 = data[31:0], data[63:32], addr[31:0], addr[63:32], {24'b0, opcode}. Upper 24 bits of word 4 are ignored, with no error.
- Write channel FSM states:
  - e_idle: awready = wready = 1 unless blocked. AW and W may arrive in either order or the same cycle; each is captured independently into a holding register.
  - e_resp: entered the cycle after both AW and W are held. Asserts bvalid; returns to e_idle on bvalid & bready. No new AW/W is accepted while in e_resp. One outstanding write only.
- Word commit: happens on entry to e_resp.
  - If awaddr == nbf_host_addr_p and done_o == 0: store the word at the current index; bresp OKAY.
  - Otherwise: discard the word; counter unchanged; bresp SLVERR.
- Output: commit of word 4 loads nbf_o and sets nbf_v_o the next cycle; the word counter clears to 0.
  - nbf_v_o holds until nbf_v_o & nbf_ready_i, with nbf_o stable meanwhile.
- Backpressure: while nbf_v_o = 1, awready = wready = 0. The next command's words are not accepted until the handshake.
- Finish: an opcode 8'hFF command is still presented on nbf_o. done_o rises the cycle after its handshake and stays high until reset.
- Read channel: single outstanding read. arready = ~rvalid. On AR handshake, rvalid = 1 next cycle with rdata = delivered count (16 bits, zero-extended, saturating at 16'hFFFF); held until rready.
- Delivered count increments on each nbf_o handshake. Reads and writes proceed independently.
- Reset asserted mid-command: the partial command is lost and any pending B/R response is dropped.

Decomposition:
- Shared package: bp_nbf_s packed struct (opcode 8, addr 64, data 64), nbf_flits_lp = 5, opcode constant e_nbf_finish = 8'hFF, AXI response encodings OKAY/SLVERR.
- One natural sub-module: bsg_counter_clear_up as the word index counter (max_val_p 4).

Test Plan:
- Five writes to 64'h0, words 0x89ABCDEF, 0x01234567, 0x00001000, 0x00000080, 0x00000002 (AW and W in the same cycle) -> one nbf_o = {8'h02, 64'h80_0000_1000, 64'h0123_4567_89AB_CDEF}, five OKAY responses.
- Same stream, W leading AW by 3 cycles on word 2 and AW leading W by 2 cycles on word 3 -> identical nbf_o; each bvalid appears only after both channels are held.
- Word to address 64'h40 in the middle of a command -> SLVERR, word discarded; the following valid words complete the command correctly.
- nbf_ready_i held low 20 cycles after command 1; host starts command 2 -> awready/wready stay 0 until the handshake; both commands delivered in order, unmodified.
- Finish command {8'hFF, 0, 0} -> presented on nbf_o; done_o = 1 after the handshake; a later write -> SLVERR; a read returns the delivered count including the finish command.
- Reset asserted after 3 of 5 words, then a full command sent -> only the new command is emitted; a read returns 1.
